npc_fetch_unit: RTL and testbench
=================================

// Module: npc_fetch_unit
// PURPOSE
//  Parametrised next-PC generator with the fetch PC register built in. Resolves branch/jump
//  targets from the D-stage instruction and supports six compare conditions for branches.
//  Adds stall hold, a deferred-redirect latch, exception entry and ERET return.
//  Sits between the F-stage IM address and the D-stage decoder/GPR read ports.
// PARAMETERS
//  ADDR_W     32            PC width in bits; must be >= 28
//  RESET_PC   32'h0000_3000 pc value after reset (truncated to ADDR_W)
//  EXC_VECTOR 32'h0000_4180 pc loaded on exc_req (truncated to ADDR_W)
// PORTS
//  clk              in   1       clock; all state changes on the rising edge
//  reset            in   1       synchronous, active-high reset
//  stall            in   1       hold pc (pipeline stall from the hazard unit)
//  npc_op           in   3       0 seq, 1 branch, 2 j/jal, 3 jr/jalr, 4-7 treated as seq
//  cmp_op           in   3       0 eq, 1 ne, 2 lez, 3 gtz, 4 ltz, 5 gez, 6-7 never taken
//  pc_d             in   ADDR_W  PC of the D-stage instruction owning npc_op
//  rs_val           in   32      forwarded GPR[rs]
//  rt_val           in   32      forwarded GPR[rt]
//  imm26            in   26      instr[25:0]; branches use imm26[15:0]
//  exc_req          in   1       take exception: redirect to EXC_VECTOR
//  eret_req         in   1       return from exception: redirect to epc
//  epc              in   ADDR_W  exception return address from CP0
//  pc               out  ADDR_W  current fetch PC (registered)
//  pc8_d            out  ADDR_W  pc_d + 8, link value for jal/jalr (combinational)
//  br_taken         out  1       combinational: branch/jump redirect requested this cycle
//  redirect_pending out  1       registered: a deferred redirect is held in the latch
//  adel_f           out  1       combinational: pc[1:0] != 0 (fetch address error)
// BEHAVIOUR
//  Reset: pc=RESET_PC, redirect_pending=0, latched target=0; reset beats all other inputs.
//  Target computation (ADDR_W arithmetic, wrap modulo 2^ADDR_W, no overflow flag):
//   branch: pc_d + 4 + (sext(imm26[15:0]) << 2).
//   j/jal: {(pc_d+4)[ADDR_W-1:28], imm26, 2'b00}.
//   jr/jalr: rs_val zero-extended or truncated to ADDR_W.
//  Compare (signed 32-bit): eq rs==rt; ne rs!=rt; lez rs<=0; gtz rs>0; ltz rs<0; gez rs>=0.
//  br_taken = (npc_op==2) | (npc_op==3) | (npc_op==1 & cond).
//  Next-pc priority each edge, highest first:
//   1. exc_req: pc<=EXC_VECTOR; pending cleared; ignores stall.
//   2. eret_req: pc<=epc; pending cleared; ignores stall.
//   3. stall=1 and br_taken: pc holds; pending<=1; latch<=target. Last request wins.
//   4. stall=1, no br_taken: pc holds; pending and latch unchanged.
//   5. stall=0 and br_taken: pc<=target; pending cleared.
//   6. stall=0 and pending: pc<=latch; pending cleared.
//   7. otherwise: pc<=pc+4.
//  Delay slot: the redirect applies to the fetch after the slot instruction, so 1-cycle
//   redirect latency. The slot instruction is already in F when the D-stage branch resolves.
//  Misaligned jr target is loaded unchanged; adel_f flags it. The exception logic decides.
//  Reset mid-stall or with pending=1: pending is discarded and pc=RESET_PC.
//  npc_op 4-7 and cmp_op 6-7 never redirect. No X propagation from unused inputs.
// TESTING
//  Reset: hold reset 2 cycles with stall=1 and exc_req=1 -> pc=0x3000, pending=0.
//   Then 3 free cycles -> pc=0x3004, 0x3008, 0x300C.
//  Branch: pc_d=0x3010, npc_op=1, cmp_op=0, rs=rt=5, imm=0xFFFF.
//   -> br_taken=1; next pc=0x3010; with rt=6 -> br_taken=0, pc+4.
//  Compare sweep: rs in {0x80000000, 0, 1}, cmp_op 2..5.
//   -> taken only for lez{neg,0}, gtz{1}, ltz{neg}, gez{0,1}; cmp_op 7 never taken.
//  j and jr: j with pc_d=0x3FFF_FFFC, imm26=0x100 -> pc=0x4000_0400, pc8_d=0x4000_0004.
//   jr rs=0x3002 -> pc=0x3002, adel_f=1.
//  Stall and defer: stall=1 for 3 cycles, j to 0x3100 in cycle 1 and j to 0x3200 in cycle 2.
//   -> pc frozen and pending=1; first unstalled edge -> pc=0x3200, pending=0.
//  Exception priority: exc_req=1 with eret_req=1, stall=1, br_taken=1, pending=1.
//   -> pc=0x4180, pending=0. Next cycle eret_req=1, epc=0x3040 -> pc=0x3040.

Source files
------------

// File: rtl/npc_fetch_unit.sv
// Next-PC generator with the fetch PC register built in.
// Resolves branch, jump and register-jump targets from the D-stage
// instruction and evaluates six signed compare conditions for branches.
// Supports stall hold, a deferred-redirect latch, exception entry and ERET return.
// Interface timing: there is no valid/ready handshake. Every input is sampled
// on each rising edge. `stall` only freezes the fetch PC. A redirect
// requested while stalled is parked in the latch and replayed on the first
// unstalled edge. A newer request made during the same stall overwrites the
// parked one.
module npc_fetch_unit #(
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [2:0]        npc_op,
  input  logic [2:0]        cmp_op,
  input  logic [ADDR_W-1:0] pc_d,
  input  logic [31:0]       rs_val,
  input  logic [31:0]       rt_val,
  input  logic [25:0]       imm26,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc8_d,
  output logic              br_taken,
  output logic              redirect_pending,
  output logic              adel_f
);

  localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] EXC_VAL   = ADDR_W'(EXC_VECTOR);
  // The low 28 bits of a j/jal target come from the instruction.
  // The upper bits are kept from pc_d + 4.
  localparam logic [ADDR_W-1:0] LOW28     = ADDR_W'(28'hFFF_FFFF);

  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_J      = 3'd2;
  localparam logic [2:0] NPC_JR     = 3'd3;

  // Redirect tracking: NONE = nothing parked, HELD = latch holds a target.
  typedef enum logic {
    REDIR_NONE = 1'b0,
    REDIR_HELD = 1'b1
  } redir_state_t;

  redir_state_t      state, state_next;
  logic [ADDR_W-1:0] latch, latch_next;
  logic [ADDR_W-1:0] pc_next;

  logic [ADDR_W-1:0] pc_d_plus4;
  logic [ADDR_W-1:0] br_offset;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] jr_target;
  logic [ADDR_W-1:0] target;
  logic              rs_neg;
  logic              rs_zero;
  logic              cond;

  // Target candidates. All arithmetic wraps modulo 2^ADDR_W.
  always_comb begin
    pc_d_plus4 = pc_d + ADDR_W'(4);
    br_offset  = {{(ADDR_W-18){imm26[15]}}, imm26[15:0], 2'b00};
    br_target  = pc_d_plus4 + br_offset;
    j_target   = (pc_d_plus4 & ~LOW28) | ADDR_W'({imm26, 2'b00});
    jr_target  = ADDR_W'(rs_val);
  end

  // Signed branch condition on the forwarded operands.
  // cmp_op values 6 and 7 are never taken.
  always_comb begin
    rs_neg  = rs_val[31];
    rs_zero = (rs_val == 32'd0);
    cond    = 1'b0;
    case (cmp_op)
      3'd0:    cond = (rs_val == rt_val);
      3'd1:    cond = (rs_val != rt_val);
      3'd2:    cond = rs_neg | rs_zero;
      3'd3:    cond = ~rs_neg & ~rs_zero;
      3'd4:    cond = rs_neg;
      3'd5:    cond = ~rs_neg;
      default: cond = 1'b0;
    endcase
  end

  // Redirect request and selected target. npc_op values 4 to 7 act as sequential.
  always_comb begin
    br_taken = 1'b0;
    target   = '0;
    case (npc_op)
      NPC_BRANCH: begin
        br_taken = cond;
        target   = br_target;
      end
      NPC_J: begin
        br_taken = 1'b1;
        target   = j_target;
      end
      NPC_JR: begin
        br_taken = 1'b1;
        target   = jr_target;
      end
      default: begin
        br_taken = 1'b0;
        target   = '0;
      end
    endcase
  end

  // Next-PC priority: exception, eret, stall (park any redirect), live redirect, parked redirect, pc+4.
  always_comb begin
    pc_next    = pc + ADDR_W'(4);
    state_next = state;
    latch_next = latch;
    if (exc_req) begin
      pc_next    = EXC_VAL;
      state_next = REDIR_NONE;
    end else if (eret_req) begin
      pc_next    = epc;
      state_next = REDIR_NONE;
    end else if (stall) begin
      pc_next = pc;
      if (br_taken) begin
        state_next = REDIR_HELD;
        latch_next = target;
      end
    end else if (br_taken) begin
      pc_next    = target;
      state_next = REDIR_NONE;
    end else if (state == REDIR_HELD) begin
      pc_next    = latch;
      state_next = REDIR_NONE;
    end
  end

  // State registers. Reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_VAL;
      state <= REDIR_NONE;
      latch <= '0;
    end else begin
      pc    <= pc_next;
      state <= state_next;
      latch <= latch_next;
    end
  end

  // Link value and fetch-address alignment flag.
  always_comb begin
    pc8_d            = pc_d + ADDR_W'(8);
    adel_f           = (pc[1:0] != 2'b00);
    redirect_pending = (state == REDIR_HELD);
  end

endmodule

// File: tb/tb_npc_fetch_unit.sv
// Testbench for npc_fetch_unit. It contains a table of vectors, hand-written
// corner-case sequences and randomized cycles checked against a reference model.
module tb_npc_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, exc_req, eret_req;
  logic [2:0]  npc_op, cmp_op;
  logic [31:0] pc_d, rs_val, rt_val, epc;
  logic [25:0] imm26;
  logic [31:0] pc, pc8_d;
  logic        br_taken, redirect_pending, adel_f;

  npc_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op), .cmp_op(cmp_op),
    .pc_d(pc_d), .rs_val(rs_val), .rt_val(rt_val), .imm26(imm26),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .pc(pc), .pc8_d(pc8_d), .br_taken(br_taken),
    .redirect_pending(redirect_pending), .adel_f(adel_f)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_latch;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_taken(input logic [2:0] op, input logic [2:0] cmp,
                                       input logic [31:0] rs, input logic [31:0] rt);
    int s;
    logic c;
    s = int'(rs);
    case (cmp)
      3'd0: c = (rs == rt);
      3'd1: c = (rs != rt);
      3'd2: c = (s <= 0);
      3'd3: c = (s > 0);
      3'd4: c = (s < 0);
      3'd5: c = (s >= 0);
      default: c = 1'b0;
    endcase
    return (op == 3'd2) || (op == 3'd3) || (op == 3'd1 && c);
  endfunction

  function automatic logic [31:0] model_target(input logic [2:0] op, input logic [31:0] pcd,
                                               input logic [25:0] imm, input logic [31:0] rs);
    int off;
    logic [15:0] half;
    half = imm[15:0];
    off  = int'($signed(half));
    case (op)
      3'd1:    return pcd + 32'd4 + 32'(off * 4);
      3'd2:    return ((pcd + 32'd4) & 32'hF000_0000) + 32'(imm) * 32'd4;
      3'd3:    return rs;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic st, input logic [2:0] op, input logic [2:0] cmp,
                       input logic [31:0] pcd, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [25:0] imm);
    stall = st; npc_op = op; cmp_op = cmp; pc_d = pcd;
    rs_val = rs; rt_val = rt; imm26 = imm;
  endtask

  // One clock cycle. Inputs are already set at posedge+1.
  // Combinational outputs are checked at the negedge and registers at posedge+1.
  task automatic step(input string tag);
    logic tk;
    logic [31:0] tg;
    @(negedge clk);
    tk = model_taken(npc_op, cmp_op, rs_val, rt_val);
    tg = model_target(npc_op, pc_d, imm26, rs_val);
    check({tag, ".br_taken"}, 32'(br_taken), 32'(tk));
    check({tag, ".pc8_d"}, pc8_d, pc_d + 32'd8);
    check({tag, ".adel_f"}, 32'(adel_f), 32'(m_pc[1:0] != 2'b00));
    if (reset) begin
      m_pc = 32'h0000_3000; m_pend = 1'b0; m_latch = 32'd0;
    end else if (exc_req) begin
      m_pc = 32'h0000_4180; m_pend = 1'b0;
    end else if (eret_req) begin
      m_pc = epc; m_pend = 1'b0;
    end else if (stall) begin
      if (tk) begin m_pend = 1'b1; m_latch = tg; end
    end else if (tk) begin
      m_pc = tg; m_pend = 1'b0;
    end else if (m_pend) begin
      m_pc = m_latch; m_pend = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    exp_q.push_back(m_pc);
    @(posedge clk);
    #1;
    check({tag, ".pc"}, pc, exp_q.pop_front());
    check({tag, ".pending"}, 32'(redirect_pending), 32'(m_pend));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  op;
    logic [2:0]  cmp;
    logic [31:0] pcd;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [25:0] imm;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset = 1'b1; stall = 1'b1; exc_req = 1'b1; eret_req = 1'b0; epc = 32'd0;
    drive(1'b1, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0, 26'd0);

    // Reset held two cycles with stall and exc_req asserted.
    @(posedge clk); @(posedge clk); #1;
    check("reset.pc", pc, 32'h0000_3000);
    check("reset.pending", 32'(redirect_pending), 32'd0);
    m_pc = 32'h0000_3000; m_pend = 1'b0; m_latch = 32'd0;
    reset = 1'b0; exc_req = 1'b0;
    drive(1'b0, 3'd0, 3'd0, 32'h3000, 32'd0, 32'd0, 26'd0);
    for (int i = 0; i < 3; i++) begin
      step("seq");
      check("seq.const", pc, 32'h0000_3004 + 32'(i) * 32'd4);
    end

    // Branch, compare sweep and never-taken encodings.
    vecs.push_back('{3'd1, 3'd0, 32'h3010, 32'd5, 32'd5, 26'h0FFFF, 1'b1});
    vecs.push_back('{3'd1, 3'd0, 32'h3010, 32'd5, 32'd6, 26'h0FFFF, 1'b0});
    vecs.push_back('{3'd1, 3'd1, 32'h3010, 32'd5, 32'd6, 26'h00004, 1'b1});
    vecs.push_back('{3'd1, 3'd2, 32'h3020, 32'h8000_0000, 32'd0, 26'h8, 1'b1});
    vecs.push_back('{3'd1, 3'd2, 32'h3020, 32'd0, 32'd0, 26'h8, 1'b1});
    vecs.push_back('{3'd1, 3'd2, 32'h3020, 32'd1, 32'd0, 26'h8, 1'b0});
    vecs.push_back('{3'd1, 3'd3, 32'h3020, 32'h8000_0000, 32'd0, 26'h8, 1'b0});
    vecs.push_back('{3'd1, 3'd3, 32'h3020, 32'd0, 32'd0, 26'h8, 1'b0});
    vecs.push_back('{3'd1, 3'd3, 32'h3020, 32'd1, 32'd0, 26'h8, 1'b1});
    vecs.push_back('{3'd1, 3'd4, 32'h3020, 32'h8000_0000, 32'd0, 26'h8, 1'b1});
    vecs.push_back('{3'd1, 3'd4, 32'h3020, 32'd0, 32'd0, 26'h8, 1'b0});
    vecs.push_back('{3'd1, 3'd4, 32'h3020, 32'd1, 32'd0, 26'h8, 1'b0});
    vecs.push_back('{3'd1, 3'd5, 32'h3020, 32'h8000_0000, 32'd0, 26'h8, 1'b0});
    vecs.push_back('{3'd1, 3'd5, 32'h3020, 32'd0, 32'd0, 26'h8, 1'b1});
    vecs.push_back('{3'd1, 3'd5, 32'h3020, 32'd1, 32'd0, 26'h8, 1'b1});
    vecs.push_back('{3'd1, 3'd7, 32'h3020, 32'd0, 32'd0, 26'h8, 1'b0});
    vecs.push_back('{3'd1, 3'd6, 32'h3020, 32'd5, 32'd5, 26'h8, 1'b0});
    vecs.push_back('{3'd5, 3'd0, 32'h3020, 32'd5, 32'd5, 26'h8, 1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b0, vecs[i].op, vecs[i].cmp, vecs[i].pcd, vecs[i].rs, vecs[i].rt, vecs[i].imm);
      #1;
      check($sformatf("vec%0d.taken", i), 32'(br_taken), 32'(vecs[i].exp_taken));
      if (i == 0) begin
        step("vec0");
        check("branch.back", pc, 32'h0000_3010);
      end else begin
        step($sformatf("vec%0d", i));
      end
    end

    // j across a 256 MB region boundary, then a misaligned jr.
    drive(1'b0, 3'd2, 3'd0, 32'h3FFF_FFFC, 32'd0, 32'd0, 26'h100);
    #1 check("j.pc8_d", pc8_d, 32'h4000_0004);
    step("j");
    check("j.pc", pc, 32'h4000_0400);
    drive(1'b0, 3'd3, 3'd0, 32'h3000, 32'h3002, 32'd0, 26'd0);
    step("jr");
    check("jr.pc", pc, 32'h0000_3002);
    check("jr.adel_f", 32'(adel_f), 32'd1);

    // Stall with two deferred jumps. The last request wins.
    drive(1'b1, 3'd2, 3'd0, 32'h3000, 32'd0, 32'd0, 26'hC40);
    step("defer1");
    drive(1'b1, 3'd2, 3'd0, 32'h3000, 32'd0, 32'd0, 26'hC80);
    step("defer2");
    drive(1'b1, 3'd0, 3'd0, 32'h3000, 32'd0, 32'd0, 26'd0);
    step("defer3");
    check("defer.frozen", pc, 32'h0000_3002);
    check("defer.pending", 32'(redirect_pending), 32'd1);
    drive(1'b0, 3'd0, 3'd0, 32'h3000, 32'd0, 32'd0, 26'd0);
    step("defer.release");
    check("defer.pc", pc, 32'h0000_3200);
    check("defer.cleared", 32'(redirect_pending), 32'd0);

    // Exception beats eret, stall, a live redirect and a parked one.
    drive(1'b1, 3'd2, 3'd0, 32'h3000, 32'd0, 32'd0, 26'hC40);
    step("exc.prep");
    exc_req = 1'b1; eret_req = 1'b1; epc = 32'h3040;
    step("exc");
    check("exc.pc", pc, 32'h0000_4180);
    check("exc.pending", 32'(redirect_pending), 32'd0);
    exc_req = 1'b0;
    step("eret");
    check("eret.pc", pc, 32'h0000_3040);
    eret_req = 1'b0;

    // Reset while stalled with a parked redirect.
    drive(1'b1, 3'd3, 3'd0, 32'h3000, 32'h5000, 32'd0, 26'd0);
    step("rst.prep");
    reset = 1'b1;
    step("rst");
    check("rst.pc", pc, 32'h0000_3000);
    check("rst.pending", 32'(redirect_pending), 32'd0);
    reset = 1'b0;

    // Randomized cycles.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pool[4];
      pool[0] = 32'd0; pool[1] = 32'h8000_0000; pool[2] = 32'd7; pool[3] = $urandom;
      drive(($urandom_range(0, 9) < 3), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            $urandom & 32'hFFFF_FFFC, pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
            26'($urandom));
      reset    = ($urandom_range(0, 99) == 0);
      exc_req  = ($urandom_range(0, 29) == 0);
      eret_req = ($urandom_range(0, 29) == 0);
      epc      = $urandom;
      step($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
